// File: rtl/audio_pkg.sv
// Shared audio constants and the meter FSM state type.
// The display blocks reuse MAX_LEVEL from here as their row scale.
package audio_pkg;

  localparam int SAMPLE_W  = 12;
  localparam int LEVEL_W   = 6;
  localparam int MAX_LEVEL = 21;
  localparam int MID       = 2 ** (SAMPLE_W - 1);
  localparam int STEP      = MID / (MAX_LEVEL + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUANT   = 2'd1,
    PUBLISH = 2'd2
  } meter_state_t;

endpackage

// File: rtl/volume_quantizer.sv
// Serial threshold walk that turns a window peak into a volume level,
// followed by an optional one-step-per-window decay of the published value.
module volume_quantizer #(
  parameter int SAMPLE_W  = audio_pkg::SAMPLE_W,
  parameter int LEVEL_W   = audio_pkg::LEVEL_W,
  parameter int MAX_LEVEL = audio_pkg::MAX_LEVEL
) (
  input  logic                clk_20khz,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SAMPLE_W-2:0] work,
  input  logic                decay_en,
  output logic [LEVEL_W-1:0]  level,
  output logic                done,
  output logic                busy
);
  import audio_pkg::*;

  localparam int AMP_W = SAMPLE_W - 1;
  localparam logic [SAMPLE_W-1:0] STEP_V = SAMPLE_W'((2 ** (SAMPLE_W - 1)) / (MAX_LEVEL + 1));
  localparam logic [LEVEL_W-1:0]  MAX_V  = LEVEL_W'(MAX_LEVEL);

  meter_state_t        state;
  logic [AMP_W-1:0]    work_q;
  logic [SAMPLE_W-1:0] thr;
  logic [LEVEL_W-1:0]  lvl;

  // A rise is always taken at once; a fall is limited to one step when decaying.
  function automatic logic [LEVEL_W-1:0] decay_step(input logic en,
                                                    input logic [LEVEL_W-1:0] cur,
                                                    input logic [LEVEL_W-1:0] nxt);
    return (en && (cur > nxt)) ? (cur - LEVEL_W'(1)) : nxt;
  endfunction

  assign busy = (state != IDLE);

  always_ff @(posedge clk_20khz or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      work_q <= '0;
      thr    <= '0;
      lvl    <= '0;
      level  <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work_q <= work;
            lvl    <= '0;
            thr    <= STEP_V;
            state  <= QUANT;
          end
        end
        QUANT: begin
          if (({1'b0, work_q} >= thr) && (lvl < MAX_V)) begin
            lvl <= lvl + LEVEL_W'(1);
            thr <= thr + STEP_V;
          end else begin
            state <= PUBLISH;
          end
        end
        PUBLISH: begin
          level <= decay_step(decay_en, level, lvl);
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/volume_level_meter.sv
// Mic sample front end: amplitude about mid-scale, per-window peak hold and
// window counter, handing each closed window's peak to the quantizer.
module volume_level_meter #(
  parameter int SAMPLE_W  = audio_pkg::SAMPLE_W,
  parameter int LEVEL_W   = audio_pkg::LEVEL_W,
  parameter int MAX_LEVEL = audio_pkg::MAX_LEVEL,
  parameter int WINDOW    = 4000
) (
  input  logic                clk_20khz,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] mic_in,
  input  logic                pause_switch,
  input  logic                decay_en,
  output logic [LEVEL_W-1:0]  volume_level,
  output logic                level_valid,
  output logic [SAMPLE_W-2:0] peak_raw
);
  import audio_pkg::*;

  localparam int AMP_W = SAMPLE_W - 1;
  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  // Offset-binary to magnitude; mic_in = 0 gives MID, which does not fit and saturates.
  function automatic logic [AMP_W-1:0] sat_amp(input logic [SAMPLE_W-1:0] s);
    logic signed [SAMPLE_W:0] mid_s;
    logic signed [SAMPLE_W:0] top_s;
    logic signed [SAMPLE_W:0] diff;
    logic signed [SAMPLE_W:0] mag;
    mid_s = (SAMPLE_W + 1)'(2 ** (SAMPLE_W - 1));
    top_s = (SAMPLE_W + 1)'(2 ** AMP_W - 1);
    diff  = $signed({1'b0, s}) - mid_s;
    mag   = (diff < 0) ? -diff : diff;
    if (mag > top_s) return '1;
    return mag[AMP_W-1:0];
  endfunction

  logic [AMP_W-1:0] amp;
  logic [AMP_W-1:0] peak;
  logic [AMP_W-1:0] peak_next;
  logic [CNT_W-1:0] cnt;
  logic             take;
  logic             close;
  logic             q_busy;
  logic             q_start;

  assign amp       = sat_amp(mic_in);
  assign take      = sample_valid && !pause_switch;
  assign close     = take && (cnt == LAST);
  assign peak_next = (amp > peak) ? amp : peak;
  // A close arriving while the quantizer is still busy is dropped.
  assign q_start   = close && !q_busy;

  always_ff @(posedge clk_20khz or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      peak     <= '0;
      peak_raw <= '0;
    end else if (take) begin
      if (close) begin
        cnt  <= '0;
        peak <= '0;
        if (!q_busy) peak_raw <= peak_next;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        peak <= peak_next;
      end
    end
  end

  volume_quantizer #(
    .SAMPLE_W  (SAMPLE_W),
    .LEVEL_W   (LEVEL_W),
    .MAX_LEVEL (MAX_LEVEL)
  ) u_quant (
    .clk_20khz (clk_20khz),
    .rst_n     (rst_n),
    .start     (q_start),
    .work      (peak_next),
    .decay_en  (decay_en),
    .level     (volume_level),
    .done      (level_valid),
    .busy      (q_busy)
  );

endmodule

// File: tb/tb_volume_level_meter.sv
// Directed bench for volume_level_meter with a shortened window.
module tb_volume_level_meter;

  localparam int SAMPLE_W  = 12;
  localparam int LEVEL_W   = 6;
  localparam int MAX_LEVEL = 21;
  localparam int WINDOW    = 64;

  logic                clk_20khz = 1'b0;
  logic                rst_n;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] mic_in;
  logic                pause_switch;
  logic                decay_en;
  logic [LEVEL_W-1:0]  volume_level;
  logic                level_valid;
  logic [SAMPLE_W-2:0] peak_raw;

  int errors = 0;
  int checks = 0;

  always #5 clk_20khz = ~clk_20khz;

  volume_level_meter #(
    .SAMPLE_W  (SAMPLE_W),
    .LEVEL_W   (LEVEL_W),
    .MAX_LEVEL (MAX_LEVEL),
    .WINDOW    (WINDOW)
  ) dut (
    .clk_20khz    (clk_20khz),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .mic_in       (mic_in),
    .pause_switch (pause_switch),
    .decay_en     (decay_en),
    .volume_level (volume_level),
    .level_valid  (level_valid),
    .peak_raw     (peak_raw)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_20khz);
    #1;
  endtask

  // Feeds one window of mid-scale samples with a single peak sample at pos,
  // optionally inserting 1000 paused loud cycles before sample pause_at.
  task automatic run_window(input string tag, input logic [SAMPLE_W-1:0] pk, input int pos,
                            input int pause_at, input int exp_q, input int exp_lvl,
                            input int exp_peak);
    int   n;
    logic early;
    early = 1'b0;
    for (int i = 0; i < WINDOW; i++) begin
      if (i == pause_at) begin
        pause_switch = 1'b1;
        sample_valid = 1'b1;
        mic_in       = 12'd4095;
        for (int j = 0; j < 1000; j++) begin
          tick();
          early |= level_valid;
        end
        pause_switch = 1'b0;
      end
      sample_valid = 1'b1;
      mic_in       = (i == pos) ? pk : 12'd2048;
      tick();
      early |= level_valid;
    end
    sample_valid = 1'b0;
    mic_in       = 12'd2048;
    n = 0;
    while (!level_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_early"}, early, 0);
    check({tag, "_lat"}, n, exp_q + 2);
    check({tag, "_lvl"}, volume_level, exp_lvl);
    check({tag, "_peak"}, peak_raw, exp_peak);
    tick();
    check({tag, "_pulse_end"}, level_valid, 0);
  endtask

  initial begin
    logic seen;
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    mic_in       = 12'd2048;
    pause_switch = 1'b0;
    decay_en     = 1'b0;
    tick(); tick(); tick();
    check("rst_level", volume_level, 0);
    check("rst_valid", level_valid, 0);
    check("rst_peak", peak_raw, 0);
    rst_n = 1'b1;
    tick();

    // silence, full-scale positive / negative, threshold edges
    run_window("t1_silent", 12'd2048, 0, -1, 0, 0, 0);
    run_window("t2_max", 12'd4095, 17, -1, 21, 21, 2047);
    run_window("t2_zero", 12'd0, 40, -1, 21, 21, 2047);
    run_window("t3_pos930", 12'd2978, WINDOW - 1, -1, 10, 10, 930);
    run_window("t3_neg930", 12'd1118, 0, -1, 10, 10, 930);
    run_window("t3_929", 12'd2977, 33, -1, 9, 9, 929);

    // decay walks down one step per window
    decay_en = 1'b1;
    run_window("t4_rise", 12'd4095, 5, -1, 21, 21, 2047);
    for (int k = 1; k <= 21; k++)
      run_window($sformatf("t4_decay%0d", k), 12'd2048, 0, -1, 0, 21 - k, 0);
    run_window("t4_floor", 12'd2048, 0, -1, 0, 0, 0);
    decay_en = 1'b0;
    run_window("t4_loud", 12'd4095, 9, -1, 21, 21, 2047);
    run_window("t4_nodecay", 12'd2048, 0, -1, 0, 0, 0);

    // paused loud samples are ignored and delay the close
    run_window("t5_pause", 12'd2978, 30, 10, 10, 10, 930);

    // reset during QUANT of a level-21 window
    for (int i = 0; i < WINDOW; i++) begin
      sample_valid = 1'b1;
      mic_in       = (i == 5) ? 12'd4095 : 12'd2048;
      tick();
    end
    sample_valid = 1'b0;
    mic_in       = 12'd2048;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    check("t6_rst_level", volume_level, 0);
    check("t6_rst_valid", level_valid, 0);
    check("t6_rst_peak", peak_raw, 0);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      seen |= level_valid;
    end
    check("t6_no_pulse", seen, 0);
    run_window("t6_after", 12'd2048, 0, -1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
